// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard receiver.
//   frame_state_e   : states of the serial frame FSM
//   PS2_PREFIX_EXT  : scan-code prefix marking an extended key (0xE0)
//   PS2_PREFIX_REL  : scan-code prefix marking a key release / break (0xF0)
//   odd_parity_ok() : true when data bits plus parity bit carry odd parity
// ----------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

    // PS/2 uses odd parity: the 8 data bits plus the parity bit must hold
    // an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data,
                                           input logic       par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ----------------------------------------------------------------------------
// ps2_frame_rx
// Receives one 11-bit PS/2 frame (start, 8 data LSB first, odd parity, stop)
// from the raw keyboard lines and reports each byte that arrives intact.
//
// Parameters
//   IDLE_CYCLES : clk cycles without a ps2_clk falling edge before a partial
//                 frame is abandoned
//   SYNC_STAGES : synchronizer depth on ps2_clk and ps2_data
//
// Ports
//   clk        in   system clock (rising edge)
//   rst_n      in   asynchronous active-low reset
//   ps2_clk    in   raw PS/2 clock, asynchronous
//   ps2_data   in   raw PS/2 data, asynchronous
//   data_byte  out  last received data byte (meaningful when byte_valid=1)
//   byte_valid out  one-cycle pulse, in the stop-bit edge cycle, for a good byte
//   err        out  one-cycle pulse on a start, parity, stop or timeout error
// ----------------------------------------------------------------------------
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int IDLE_CYCLES = 2750,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       err
);

    localparam int TW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(IDLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_s;
    logic                   data_s;
    logic                   clk_prev;
    logic                   fall;

    frame_state_e           state;
    frame_state_e           state_next;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift_reg;
    logic                   parity_bit;
    logic [TW-1:0]          idle_cnt;
    logic                   timeout;

    // Synchronizers preset to 1 so the bus looks idle-high out of reset.
    // Written as a shift so a single-stage configuration still elaborates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= (clk_sync << 1) | SYNC_STAGES'(ps2_clk);
            data_sync <= (data_sync << 1) | SYNC_STAGES'(ps2_data);
            clk_prev  <= clk_s;
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = clk_prev & ~clk_s;

    // An edge in the same cycle restarts the count, so it always beats the
    // timeout.
    assign timeout = (state != IDLE) && !fall && (idle_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        byte_valid = 1'b0;
        err        = 1'b0;
        if (timeout) begin
            state_next = IDLE;
            err        = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!data_s) begin
                        state_next = DATA;
                    end else begin
                        err = 1'b1;
                    end
                end
                DATA: begin
                    if (bit_cnt == 3'd7) begin
                        state_next = PARITY;
                    end
                end
                PARITY: begin
                    state_next = STOP;
                end
                STOP: begin
                    state_next = IDLE;
                    if (data_s && odd_parity_ok(shift_reg, parity_bit)) begin
                        byte_valid = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Bit capture happens only on falling-edge cycles; the PS/2 device
    // guarantees data is stable around that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            parity_bit <= 1'b0;
        end else if (fall && !timeout) begin
            case (state)
                IDLE: begin
                    bit_cnt <= 3'd0;
                end
                DATA: begin
                    shift_reg <= {data_s, shift_reg[7:1]};
                    bit_cnt   <= bit_cnt + 3'd1;
                end
                PARITY: begin
                    parity_bit <= data_s;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (fall || timeout || state == IDLE) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end

    assign data_byte = shift_reg;

endmodule

// File: rtl/ps2_rx_ctrl.sv
// ----------------------------------------------------------------------------
// ps2_rx_ctrl
// PS/2 keyboard receiver: frames bytes from the keyboard lines, folds the
// 0xE0 / 0xF0 prefixes into flags, and presents one key event at a time
// through a valid/ready register.
//
// Parameters
//   IDLE_CYCLES : clk cycles without a ps2_clk falling edge before a partial
//                 frame aborts (2750 = 55 us at 50 MHz)
//   SYNC_STAGES : synchronizer depth on ps2_clk and ps2_data
//
// Ports
//   clk          in   system clock (rising edge)
//   rst_n        in   asynchronous active-low reset
//   ps2_clk      in   raw PS/2 clock, asynchronous
//   ps2_data     in   raw PS/2 data, asynchronous
//   key_code     out  scan code of the event, prefixes removed
//   key_extended out  event was preceded by 0xE0
//   key_release  out  event was preceded by 0xF0
//   key_valid    out  event presented; held until accepted
//   key_ready    in   consumer accepts when key_valid=1 in the same cycle
//   frame_error  out  one-cycle pulse on any frame error
//   overflow     out  one-cycle pulse when a completed event is dropped
// ----------------------------------------------------------------------------
module ps2_rx_ctrl
    import ps2_pkg::*;
#(
    parameter int IDLE_CYCLES = 2750,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_release,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       frame_error,
    output logic       overflow
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;
    logic       ext_flag;
    logic       rel_flag;
    logic       is_ext;
    logic       is_rel;
    logic       new_event;
    logic       can_load;

    ps2_frame_rx #(
        .IDLE_CYCLES (IDLE_CYCLES),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_frame_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .data_byte  (rx_byte),
        .byte_valid (rx_valid),
        .err        (rx_err)
    );

    assign is_ext    = (rx_byte == PS2_PREFIX_EXT);
    assign is_rel    = (rx_byte == PS2_PREFIX_REL);
    assign new_event = rx_valid && !is_ext && !is_rel;

    // The output slot is free if empty or being drained this very cycle.
    assign can_load  = !key_valid || key_ready;

    // Prefix flags accumulate until a real scan code consumes them. A frame
    // error means the prefix context can no longer be trusted, so drop it.
    // The flags are consumed even when the event itself is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_flag <= 1'b0;
            rel_flag <= 1'b0;
        end else if (rx_err) begin
            ext_flag <= 1'b0;
            rel_flag <= 1'b0;
        end else if (rx_valid) begin
            if (is_ext) begin
                ext_flag <= 1'b1;
            end else if (is_rel) begin
                rel_flag <= 1'b1;
            end else begin
                ext_flag <= 1'b0;
                rel_flag <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code     <= 8'h00;
            key_extended <= 1'b0;
            key_release  <= 1'b0;
            key_valid    <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (new_event && can_load) begin
                key_code     <= rx_byte;
                key_extended <= ext_flag;
                key_release  <= rel_flag;
                key_valid    <= 1'b1;
            end else if (new_event) begin
                overflow <= 1'b1;
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

    // rx_err and rx_valid are mutually exclusive, which keeps frame_error
    // and overflow apart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_error <= 1'b0;
        end else begin
            frame_error <= rx_err;
        end
    end

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ps2_rx_ctrl
// Self-checking bench for ps2_rx_ctrl. Frames are bit-banged onto the PS/2
// lines; a monitor records every accepted event and every error/overflow
// pulse, and each scenario task compares those records with expectations
// derived from the PS/2 framing and prefix rules.
// ----------------------------------------------------------------------------
module tb_ps2_rx_ctrl;

    localparam int TB_IDLE = 300;
    localparam int HALF    = 20;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_release;
    logic       key_valid;
    logic       key_ready;
    logic       frame_error;
    logic       overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [9:0] got_q[$];
    int         err_cnt   = 0;
    int         ovf_cnt   = 0;
    int         vcycles   = 0;
    int         both_cnt  = 0;

    ps2_rx_ctrl #(
        .IDLE_CYCLES (TB_IDLE),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .key_code     (key_code),
        .key_extended (key_extended),
        .key_release  (key_release),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .frame_error  (frame_error),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (key_valid && key_ready) got_q.push_back({key_extended, key_release, key_code});
            if (key_valid) vcycles++;
            if (frame_error) err_cnt++;
            if (overflow) ovf_cnt++;
            if (frame_error && overflow) both_cnt++;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Send the first nbits of a frame: start, 8 data LSB first, parity, stop.
    task automatic send_frame(input logic [7:0] b, input bit bad_parity, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_parity, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_cycles(HALF);
            ps2_clk = 1'b0;
            wait_cycles(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cycles(2 * HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 11);
    endtask

    task automatic check_event(input string name, input int idx, input logic [9:0] exp);
        tests_run++;
        if (idx >= got_q.size()) begin
            tests_failed++;
            $display("[TB] FAIL %s: no event at index %0d, expected %h", name, idx, exp);
        end else if (got_q[idx] !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, got_q[idx], exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        key_ready = 1'b0;
        repeat (5) @(negedge clk);
        tests_run++;
        if ({key_code, key_extended, key_release, key_valid, frame_error, overflow} !== 13'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {key_code, key_extended, key_release, key_valid, frame_error, overflow});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_cycles(10);
        check_int("reset_no_valid", int'(key_valid), 0);
    endtask

    task automatic test_basic;
        int q0, v0, e0;
        q0 = got_q.size(); v0 = vcycles; e0 = err_cnt;
        key_ready = 1'b1;
        send_byte(8'h1C);
        check_int("basic_count", got_q.size() - q0, 1);
        check_event("basic_event", q0, {2'b00, 8'h1C});
        check_int("basic_valid_cycles", vcycles - v0, 1);
        check_int("basic_no_err", err_cnt - e0, 0);
    endtask

    task automatic test_prefix_hold;
        int q0;
        q0 = got_q.size();
        key_ready = 1'b0;
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        check_int("hold_valid", int'(key_valid), 1);
        wait_cycles(50);
        tests_run++;
        if ({key_valid, key_extended, key_release, key_code} !== {3'b111, 8'h75}) begin
            tests_failed++;
            $display("[TB] FAIL hold_stable: got %h expected %h",
                     {key_valid, key_extended, key_release, key_code}, {3'b111, 8'h75});
        end
        key_ready = 1'b1;
        wait_cycles(1);
        key_ready = 1'b0;
        check_int("hold_drop_after_accept", int'(key_valid), 0);
        check_int("hold_count", got_q.size() - q0, 1);
        check_event("hold_event", q0, {2'b11, 8'h75});
    endtask

    task automatic test_parity_error;
        int q0, e0;
        q0 = got_q.size(); e0 = err_cnt;
        key_ready = 1'b1;
        send_byte(8'hE0);
        send_frame(8'h1C, 1'b1, 11);
        check_int("parity_err_pulse", err_cnt - e0, 1);
        check_int("parity_no_event", got_q.size() - q0, 0);
        send_byte(8'h32);
        check_event("parity_next_event", q0, {2'b00, 8'h32});
    endtask

    task automatic test_timeout;
        int q0, e0;
        q0 = got_q.size(); e0 = err_cnt;
        key_ready = 1'b1;
        send_byte(8'hF0);
        send_frame(8'h5A, 1'b0, 5);
        wait_cycles(TB_IDLE + 100);
        check_int("timeout_err_once", err_cnt - e0, 1);
        send_byte(8'h1C);
        check_int("timeout_err_total", err_cnt - e0, 1);
        check_event("timeout_next_event", q0, {2'b00, 8'h1C});
    endtask

    task automatic test_overflow;
        int q0, o0;
        q0 = got_q.size(); o0 = ovf_cnt;
        key_ready = 1'b0;
        send_byte(8'h1C);
        send_byte(8'h32);
        check_int("ovf_pulse", ovf_cnt - o0, 1);
        check_int("ovf_keep_code", int'(key_code), 'h1C);
        check_int("ovf_keep_valid", int'(key_valid), 1);
        key_ready = 1'b1;
        wait_cycles(3);
        check_int("ovf_drain_count", got_q.size() - q0, 1);
        check_event("ovf_drain_event", q0, {2'b00, 8'h1C});
    endtask

    task automatic test_reset_midstream;
        int q0;
        key_ready = 1'b1;
        send_byte(8'hF0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        wait_cycles(5);
        rst_n = 1'b1;
        wait_cycles(5);
        q0 = got_q.size();
        send_byte(8'h1C);
        check_int("rst_mid_count", got_q.size() - q0, 1);
        check_event("rst_mid_event", q0, {2'b00, 8'h1C});
    endtask

    // Reference model: walk the byte list applying the prefix rules directly.
    task automatic test_random;
        logic [7:0] bytes[$];
        bit         bads[$];
        logic [9:0] exp_q[$];
        int         exp_errs, q0, e0, r;
        bit         ext, rel;
        q0 = got_q.size(); e0 = err_cnt;
        key_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            r = int'($urandom_range(0, 5));
            if (r == 0)      bytes.push_back(8'hE0);
            else if (r == 1) bytes.push_back(8'hF0);
            else             bytes.push_back(8'($urandom_range(0, 255)));
            bads.push_back($urandom_range(0, 6) == 0);
        end
        bytes.push_back(8'h29);
        bads.push_back(1'b0);
        ext = 0; rel = 0; exp_errs = 0;
        foreach (bytes[i]) begin
            if (bads[i]) begin
                exp_errs++; ext = 0; rel = 0;
            end else if (bytes[i] == 8'hE0) begin
                ext = 1;
            end else if (bytes[i] == 8'hF0) begin
                rel = 1;
            end else begin
                exp_q.push_back({ext, rel, bytes[i]});
                ext = 0; rel = 0;
            end
            send_frame(bytes[i], bads[i], 11);
        end
        check_int("rand_count", got_q.size() - q0, exp_q.size());
        check_int("rand_errs", err_cnt - e0, exp_errs);
        foreach (exp_q[i]) check_event("rand_event", q0 + i, exp_q[i]);
        check_int("err_ovf_exclusive", both_cnt, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prefix_hold();
        test_parity_error();
        test_timeout();
        test_overflow();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
